cmp6_flags_unit: RTL and testbench

- Registered magnitude/equality comparator for two WIDTH-bit operands, default 6 bits.
- Produces signed less-than (lt), unsigned less-than (ltu) and equality (eq) flags.
- Used as a flag-generation stage feeding branch and condition logic.
- One-cycle registered latency with a valid qualifier.

---
 rtl/cmp_pkg.sv | 35 +++
 rtl/cmp6_flags_unit_if.sv | 41 ++++
 rtl/cmp_core.sv | 32 +++
 rtl/cmp6_flags_unit.sv | 49 ++++
 tb/tb_cmp6_flags_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the cmp6_flags_unit comparator slice.
// CMP_EXT_FLAGS_EN adds gt/gtu/ge/geu to the flag bundle.
package cmp_pkg;

   localparam int unsigned CMP_DEFAULT_WIDTH = 6;

   typedef struct packed {
      logic lt;
      logic ltu;
      logic eq;
`ifdef CMP_EXT_FLAGS_EN
      logic gt;
      logic gtu;
      logic ge;
      logic geu;
`endif
   } cmp_flags_t;

   // Operands arrive zero-extended to 32 bits; width selects the sign bit.
   function automatic logic cmp_signed_lt(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned width);
      logic [31:0] mask;
      logic [31:0] ta;
      logic [31:0] tb;
      mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      ta   = a >> (width - 1);
      tb   = b >> (width - 1);
      if (ta[0] != tb[0]) begin
         return ta[0];
      end
      return (a & mask) < (b & mask);
   endfunction

endpackage

// File: rtl/cmp6_flags_unit_if.sv
// Operand/flag bundle between a requester and cmp6_flags_unit.
// CMP_EXT_FLAGS_EN adds the gt/gtu/ge/geu flag signals.
interface cmp6_flags_unit_if #(
   parameter int unsigned WIDTH = cmp_pkg::CMP_DEFAULT_WIDTH
);

   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             lt;
   logic             ltu;
   logic             eq;
`ifdef CMP_EXT_FLAGS_EN
   logic             gt;
   logic             gtu;
   logic             ge;
   logic             geu;

   modport master (
      output in_valid, a, b,
      input  out_valid, lt, ltu, eq, gt, gtu, ge, geu
   );

   modport slave (
      input  in_valid, a, b,
      output out_valid, lt, ltu, eq, gt, gtu, ge, geu
   );
`else
   modport master (
      output in_valid, a, b,
      input  out_valid, lt, ltu, eq
   );

   modport slave (
      input  in_valid, a, b,
      output out_valid, lt, ltu, eq
   );
`endif

endinterface

// File: rtl/cmp_core.sv
// Purely combinational signed/unsigned/equality comparator.
// CMP_EXT_FLAGS_EN adds gt/gtu/ge/geu to the produced flags.
module cmp_core
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = CMP_DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output cmp_flags_t       flags
);

   logic [31:0] a_ext;
   logic [31:0] b_ext;

   assign a_ext = 32'(a);
   assign b_ext = 32'(b);

   always_comb begin
      flags     = '0;
      flags.ltu = (a < b);
      flags.eq  = ~|(a ^ b);
      flags.lt  = cmp_signed_lt(a_ext, b_ext, WIDTH);
`ifdef CMP_EXT_FLAGS_EN
      flags.gt  = cmp_signed_lt(b_ext, a_ext, WIDTH);
      flags.gtu = (b < a);
      flags.ge  = ~flags.lt;
      flags.geu = ~flags.ltu;
`endif
   end

endmodule

// File: rtl/cmp6_flags_unit.sv
// Registered comparator: one-cycle latency flags with valid qualifier.
// CMP_EXT_FLAGS_EN enables the registered gt/gtu/ge/geu outputs.
module cmp6_flags_unit
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = CMP_DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cmp6_flags_unit_if.slave     bus
);

   cmp_flags_t flags_d;
   cmp_flags_t flags_q;
   logic       valid_q;

   cmp_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a     (bus.a),
      .b     (bus.b),
      .flags (flags_d)
   );

   // Flags only load on a valid cycle so they hold through bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         flags_q <= '0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            flags_q <= flags_d;
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.lt        = flags_q.lt;
   assign bus.ltu       = flags_q.ltu;
   assign bus.eq        = flags_q.eq;
`ifdef CMP_EXT_FLAGS_EN
   assign bus.gt        = flags_q.gt;
   assign bus.gtu       = flags_q.gtu;
   assign bus.ge        = flags_q.ge;
   assign bus.geu       = flags_q.geu;
`endif

endmodule

// File: tb/tb_cmp6_flags_unit.sv
// Scoreboard bench for cmp6_flags_unit against an integer-arithmetic model.
// Build with CMP_EXT_FLAGS_EN to also check gt/gtu/ge/geu.
module tb_cmp6_flags_unit;
   import cmp_pkg::*;

   localparam int unsigned W = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   cmp6_flags_unit_if #(.WIDTH(W)) bus ();

   cmp6_flags_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int unsigned due;
      logic        vld;
      logic        lt;
      logic        ltu;
      logic        eq;
      logic        gt;
      logic        gtu;
      logic        ge;
      logic        geu;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        held;
   int unsigned cyc      = 0;
   int          n_checks = 0;
   int          n_fail   = 0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h a=%0h b=%0h cycle=%0d",
                  name, act, exp, bus.a, bus.b, cyc);
      end
   endtask

   function automatic int to_signed(input logic [W-1:0] v);
      int u;
      u = int'(v);
      return (u >= (1 << (W - 1))) ? u - (1 << W) : u;
   endfunction

   task automatic clear_held();
      held = '{due: 0, vld: 1'b0, lt: 1'b0, ltu: 1'b0, eq: 1'b0,
               gt: 1'b0, gtu: 1'b0, ge: 1'b0, geu: 1'b0};
   endtask

   // One input cycle: drive, update the model, queue what appears a cycle later.
   task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t e;
      int   sa;
      int   sbv;
      int   ua;
      int   ub;
      @(posedge clk);
      #1;
      bus.in_valid = v;
      bus.a        = av;
      bus.b        = bv;
      if (v) begin
         sa       = to_signed(av);
         sbv      = to_signed(bv);
         ua       = int'(av);
         ub       = int'(bv);
         held.lt  = (sa < sbv);
         held.ltu = (ua < ub);
         held.eq  = (ua == ub);
         held.gt  = (sa > sbv);
         held.gtu = (ua > ub);
         held.ge  = (sa >= sbv);
         held.geu = (ua >= ub);
         check("fn_lt", 32'(cmp_signed_lt(32'(av), 32'(bv), W)), 32'(held.lt));
      end
      e     = held;
      e.due = cyc + 1;
      e.vld = v;
      sb_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && sb_q.size() > 0 && sb_q[0].due < cyc) begin
            e = sb_q.pop_front();
            check("stale_entry", cyc, e.due);
         end else if (rst_n && sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            check("out_valid", 32'(bus.out_valid), 32'(e.vld));
            check("lt",        32'(bus.lt),        32'(e.lt));
            check("ltu",       32'(bus.ltu),       32'(e.ltu));
            check("eq",        32'(bus.eq),        32'(e.eq));
`ifdef CMP_EXT_FLAGS_EN
            check("gt",        32'(bus.gt),        32'(e.gt));
            check("gtu",       32'(bus.gtu),       32'(e.gtu));
            check("ge",        32'(bus.ge),        32'(e.ge));
            check("geu",       32'(bus.geu),       32'(e.geu));
`endif
         end
      end
   end

   initial begin : stimulus
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      clear_held();

      #3;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_lt",        32'(bus.lt),        32'd0);
      check("rst_ltu",       32'(bus.ltu),       32'd0);
      check("rst_eq",        32'(bus.eq),        32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      drive(1'b1, 6'h3F, 6'h00);
      drive(1'b1, 6'h01, 6'h3E);
      drive(1'b1, 6'h20, 6'h1F);
      drive(1'b0, 6'h2A, 6'h11);
      drive(1'b1, 6'h15, 6'h15);
      drive(1'b1, 6'h05, 6'h03);
      drive(1'b0, 6'h00, 6'h3F);

      for (int i = 0; i < 64; i++) begin
         for (int j = 0; j < 64; j++) begin
            drive(1'b1, 6'(i), 6'(j));
         end
      end

      for (int k = 0; k < 400; k++) begin
         ra = 6'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? ra : 6'($urandom);
         drive(($urandom_range(0, 3) != 0), ra, rb);
      end

      // Reset mid-stream with a live result: outputs must clear without a clock.
      drive(1'b1, 6'h3F, 6'h00);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
      check("pre_rst_lt",        32'(bus.lt),        32'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("async_rst_lt",        32'(bus.lt),        32'd0);
      check("async_rst_ltu",       32'(bus.ltu),       32'd0);
      check("async_rst_eq",        32'(bus.eq),        32'd0);
      sb_q.delete();
      clear_held();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, 6'h00, 6'h00);
      drive(1'b0, 6'h15, 6'h15);
      drive(1'b1, 6'h05, 6'h03);
      drive(1'b0, 6'h00, 6'h00);

      for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
         @(posedge clk);
      end
      #6;
      if (sb_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
